// File: rtl/write_buffer.sv
// Posted-write FIFO between the core memory port and main memory.
// Writes queue in one cycle, drain one word per free memory cycle, and reads forward the youngest match.
module write_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [XLEN-1:0] core_addr,
  input  logic [7:0]      core_data_in [0:3],
  input  logic            core_we,
  input  logic            core_re,
  output logic [7:0]      core_data_out [0:3],
  output logic            stall,
  output logic            empty,
  output logic [XLEN-1:0] mem_addr,
  output logic [7:0]      mem_data_in [0:3],
  input  logic [7:0]      mem_data_out [0:3],
  output logic            mem_write_en
);

  logic [XLEN-3:0] addr_q [DEPTH];
  logic [7:0]      data_q [DEPTH][0:3];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic       hit;
  logic [7:0] fwd_data [0:3];
  logic       enq;
  logic       drain;

  assign stall = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign enq   = core_we && !stall;

  // Scan oldest to youngest so the last valid match (nearest tail) wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '{default: 8'h00};
    for (int i = 0; i < DEPTH; i++) begin
      if (((PTR_W+1)'(i) < count) &&
          (addr_q[head + PTR_W'(i)] == core_addr[XLEN-1:2])) begin
        hit      = 1'b1;
        fwd_data = data_q[head + PTR_W'(i)];
      end
    end
  end

  always_comb begin
    if (hit) core_data_out = fwd_data;
    else     core_data_out = mem_data_out;
  end

  // A read that misses the buffer owns the memory port; otherwise drain the head entry.
  always_comb begin
    drain        = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = core_addr;
    mem_data_in  = '{default: 8'h00};
    if (!rst_b) begin
      mem_addr = '0;
    end else if (!(core_re && !hit) && (count != '0)) begin
      drain        = 1'b1;
      mem_write_en = 1'b1;
      mem_addr     = {addr_q[head], 2'b00};
      mem_data_in  = data_q[head];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)   tail <= tail + PTR_W'(1);
      if (drain) head <= head + PTR_W'(1);
      count <= count + (PTR_W+1)'(enq) - (PTR_W+1)'(drain);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail] <= core_addr[XLEN-1:2];
      data_q[tail] <= core_data_in;
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// Randomized and directed bench for write_buffer, checked against a queue-based posted-write model.
module tb_write_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] core_addr;
  logic [7:0]  core_data_in [0:3];
  logic        core_we;
  logic        core_re;
  logic [7:0]  core_data_out [0:3];
  logic        stall;
  logic        empty;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_in [0:3];
  logic [7:0]  mem_data_out [0:3];
  logic        mem_write_en;

  write_buffer #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_b(rst_b), .core_addr(core_addr), .core_data_in(core_data_in),
    .core_we(core_we), .core_re(core_re), .core_data_out(core_data_out),
    .stall(stall), .empty(empty), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_write_en(mem_write_en)
  );

  always #5 clk = ~clk;

  // Environment memory, written by the DUT's strobe; ref_mem is the model's own view.
  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] out_word;
  logic [31:0] wr_word;

  always_comb begin
    for (int i = 0; i < 4; i++) mem_data_out[i] = mem[mem_addr[11:2]][8*i +: 8];
    out_word = {core_data_out[3], core_data_out[2], core_data_out[1], core_data_out[0]};
    wr_word  = {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]};
  end

  always @(posedge clk) if (mem_write_en) mem[mem_addr[11:2]] <= wr_word;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, check combinational outputs against the model, then advance the model.
  task automatic applyStimulus(input logic we, input logic re, input logic [31:0] addr,
                               input logic [31:0] data);
    logic        hit;
    logic [31:0] fwd;
    logic        exp_drain;
    int          sz;
    core_we   = we;
    core_re   = re;
    core_addr = addr;
    for (int i = 0; i < 4; i++) core_data_in[i] = data[8*i +: 8];
    #1;
    hit = 1'b0;
    fwd = '0;
    foreach (q[k]) if (q[k].a == addr[31:2]) begin hit = 1'b1; fwd = q[k].d; end
    exp_drain = (q.size() != 0) && !(re && !hit);
    checkOutput("stall", {31'b0, stall}, {31'b0, q.size() == DEPTH});
    checkOutput("empty", {31'b0, empty}, {31'b0, q.size() == 0});
    checkOutput("mem_write_en", {31'b0, mem_write_en}, {31'b0, exp_drain});
    if (re) checkOutput("core_data_out", out_word, hit ? fwd : ref_mem[addr[11:2]]);
    if (exp_drain) begin
      checkOutput("drain_addr", mem_addr, {q[0].a, 2'b00});
      checkOutput("drain_data", wr_word, q[0].d);
    end else begin
      checkOutput("mem_addr", mem_addr, addr);
    end
    sz = q.size();
    @(posedge clk);
    if (exp_drain) begin
      ref_mem[q[0].a[9:0]] = q[0].d;
      void'(q.pop_front());
    end
    if (we && sz < DEPTH) q.push_back('{a: addr[31:2], d: data});
    @(negedge clk);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_empty", {31'b0, empty}, 32'd1);
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("rst_mem_we", {31'b0, mem_write_en}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_data", wr_word, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = (i * 32'h0101_0101) ^ 32'hA5A5_A5A5;
      ref_mem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_A5A5;
    end
    mem[32]     = 32'h55;
    ref_mem[32] = 32'h55;
    rst_b     = 1'b0;
    core_we   = 1'b0;
    core_re   = 1'b0;
    core_addr = 32'h40;
    for (int i = 0; i < 4; i++) core_data_in[i] = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    checkResetOutputs();
    @(negedge clk);
    rst_b = 1'b1;

    $display("[TB] single write");
    applyStimulus(1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

    $display("[TB] fill and stall");
    applyStimulus(1'b1, 1'b1, 32'h0, 32'h1000_0000);
    applyStimulus(1'b1, 1'b1, 32'h4, 32'h1000_0004);
    applyStimulus(1'b1, 1'b1, 32'h8, 32'h1000_0008);
    applyStimulus(1'b1, 1'b1, 32'hC, 32'h1000_000C);
    applyStimulus(1'b1, 1'b1, 32'h10, 32'h1000_0010);
    applyStimulus(1'b0, 1'b1, 32'h800, 32'h0);
    repeat (5) applyStimulus(1'b0, 1'b0, 32'h800, 32'h0);

    $display("[TB] forwarding and read priority");
    applyStimulus(1'b1, 1'b1, 32'h20, 32'h1);
    applyStimulus(1'b1, 1'b1, 32'h20, 32'h2);
    applyStimulus(1'b0, 1'b1, 32'h20, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h40, 32'h0000_0040);
    applyStimulus(1'b0, 1'b1, 32'h80, 32'h0);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h20, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h20, 32'h0);

    $display("[TB] back-to-back wrap");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'h200 + 32'(i * 4), $urandom);
    repeat (2) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      int          r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      a = (r == 9) ? (32'h600 + 32'($urandom_range(0, 15) * 4))
                   : 32'($urandom_range(0, 15) * 4);
      if (r < 4)      applyStimulus(1'b1, 1'b0, a, $urandom);
      else if (r < 7) applyStimulus(1'b0, 1'b1, a, 32'h0);
      else if (r < 8) applyStimulus(1'b1, 1'b1, a, $urandom);
      else            applyStimulus(1'b0, 1'b0, a, 32'h0);
    end
    repeat (DEPTH + 1) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

    $display("[TB] reset mid-drain");
    applyStimulus(1'b1, 1'b1, 32'h300, 32'hAAAA_0001);
    applyStimulus(1'b1, 1'b1, 32'h304, 32'hAAAA_0002);
    applyStimulus(1'b1, 1'b1, 32'h308, 32'hAAAA_0003);
    core_we = 1'b0;
    core_re = 1'b0;
    #1;
    checkOutput("pre_rst_mem_we", {31'b0, mem_write_en}, 32'd1);
    rst_b = 1'b0;
    #1;
    checkResetOutputs();
    q.delete();
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h300, 32'h0);

    for (int i = 0; i < 256; i++) checkOutput("final_mem", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
